sequenciador_preparo: RTL

SEQUENCIADOR_PREPARO -- requirements
Module: sequenciador_preparo

---
 rtl/sequenciador_preparo.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sequenciador_preparo.sv
// Drink preparation sequencer: timed PRESS/AQUEC/DISPENSA phases with abort handling,
// plus an independent sale-timeout counter that shares the same one-per-second tick.
module sequenciador_preparo #(
  parameter int T_PRESS = 2,
  parameter int T_AQUEC = 2,
  parameter int T_DISP  = 5,
  parameter int T_VENDA = 15
) (
  input  logic       clk3,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       start,
  input  logic       bebida_sel,
  input  logic       Cancel,
  input  logic       V_sense,
  input  logic       venda_ativa,
  output logic [1:0] estado,
  output logic       ocupado,
  output logic       led_press,
  output logic       led_aquec,
  output logic       led_bebida_1,
  output logic       led_bebida_2,
  output logic       fim_preparo,
  output logic       abortado,
  output logic       Temp_15
);

  localparam logic [1:0] OCIOSO   = 2'b00;
  localparam logic [1:0] PRESS    = 2'b01;
  localparam logic [1:0] AQUEC    = 2'b10;
  localparam logic [1:0] DISPENSA = 2'b11;

  logic [1:0] estado_r, estado_nxt_s;
  logic [3:0] cnt_r, cnt_nxt_s, lim_s;
  logic       sel_r, sel_nxt_s;
  logic       fim_nxt_s, abort_nxt_s;
  logic       fim_r, abort_r, ocupado_r;
  logic       led_press_r, led_aquec_r, led_b1_r, led_b2_r;
  logic [4:0] venda_cnt_r;
  logic       temp_r;

  // Last counter value of the current phase.
  always_comb begin
    lim_s = 4'd0;
    case (estado_r)
      PRESS:    lim_s = 4'(T_PRESS - 1);
      AQUEC:    lim_s = 4'(T_AQUEC - 1);
      DISPENSA: lim_s = 4'(T_DISP - 1);
      default:  lim_s = 4'd0;
    endcase
  end

  // Next-state logic; abort outranks a phase-completing tick.
  always_comb begin
    estado_nxt_s = estado_r;
    cnt_nxt_s    = cnt_r;
    sel_nxt_s    = sel_r;
    fim_nxt_s    = 1'b0;
    abort_nxt_s  = 1'b0;
    if (estado_r == OCIOSO) begin
      if (start && !V_sense && !Cancel) begin
        estado_nxt_s = PRESS;
        cnt_nxt_s    = 4'd0;
        sel_nxt_s    = bebida_sel;
      end else begin
        cnt_nxt_s = 4'd0;
      end
    end else if (V_sense || Cancel) begin
      estado_nxt_s = OCIOSO;
      cnt_nxt_s    = 4'd0;
      abort_nxt_s  = 1'b1;
    end else if (tick) begin
      if (cnt_r == lim_s) begin
        cnt_nxt_s = 4'd0;
        case (estado_r)
          PRESS:    estado_nxt_s = AQUEC;
          AQUEC:    estado_nxt_s = DISPENSA;
          DISPENSA: begin
            estado_nxt_s = OCIOSO;
            fim_nxt_s    = 1'b1;
          end
          default:  estado_nxt_s = OCIOSO;
        endcase
      end else begin
        cnt_nxt_s = cnt_r + 4'd1;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Preparation state, pulses and lamps, all registered from the next state.
  always_ff @(posedge clk3 or negedge reset_n) begin
    if (!reset_n) begin
      estado_r    <= OCIOSO;
      cnt_r       <= 4'd0;
      sel_r       <= 1'b0;
      fim_r       <= 1'b0;
      abort_r     <= 1'b0;
      ocupado_r   <= 1'b0;
      led_press_r <= 1'b0;
      led_aquec_r <= 1'b0;
      led_b1_r    <= 1'b0;
      led_b2_r    <= 1'b0;
    end else begin
      estado_r    <= estado_nxt_s;
      cnt_r       <= cnt_nxt_s;
      sel_r       <= sel_nxt_s;
      fim_r       <= fim_nxt_s;
      abort_r     <= abort_nxt_s;
      ocupado_r   <= (estado_nxt_s != OCIOSO);
      led_press_r <= (estado_nxt_s == PRESS);
      led_aquec_r <= (estado_nxt_s == AQUEC);
      led_b1_r    <= (estado_nxt_s == DISPENSA) && !sel_nxt_s;
      led_b2_r    <= (estado_nxt_s == DISPENSA) && sel_nxt_s;
    end
  end

  // Sale timeout: saturates at T_VENDA so Temp_15 fires once per active sale.
  always_ff @(posedge clk3 or negedge reset_n) begin
    if (!reset_n) begin
      venda_cnt_r <= 5'd0;
      temp_r      <= 1'b0;
    end else if (!venda_ativa) begin
      venda_cnt_r <= 5'd0;
      temp_r      <= 1'b0;
    end else if (tick && (venda_cnt_r != 5'(T_VENDA))) begin
      venda_cnt_r <= venda_cnt_r + 5'd1;
      temp_r      <= ((venda_cnt_r + 5'd1) == 5'(T_VENDA));
    end else begin
      venda_cnt_r <= venda_cnt_r;
      temp_r      <= 1'b0;
    end
  end

  assign estado       = estado_r;
  assign ocupado      = ocupado_r;
  assign led_press    = led_press_r;
  assign led_aquec    = led_aquec_r;
  assign led_bebida_1 = led_b1_r;
  assign led_bebida_2 = led_b2_r;
  assign fim_preparo  = fim_r;
  assign abortado     = abort_r;
  assign Temp_15      = temp_r;

endmodule
